// File: rtl/memory_controller_pkg.sv
// Shared types for the fetch/data memory controller: FSM state and access-source encodings.
package memory_controller_pkg;

   typedef enum logic [1:0] {
      MC_IDLE     = 2'd0,
      MC_BUSY_IF  = 2'd1,
      MC_BUSY_MEM = 2'd2,
      MC_RESP     = 2'd3
   } mc_state_e;

   typedef enum logic {
      MC_SRC_IF  = 1'b0,
      MC_SRC_MEM = 1'b1
   } mc_src_e;

   localparam int MC_CNT_W = 4;

endpackage

// File: rtl/memory_controller_if.sv
// Fetch and data-stage request/response bundle; the pipeline is master, the controller is slave.
interface memory_controller_if;

   logic        if_mc_req;
   logic [31:0] if_mc_addr;
   logic [31:0] mc_if_data;
   logic        mc_if_ack;
   logic        mc_if_stall;

   logic        mem_mc_req;
   logic        mem_mc_we;
   logic [31:0] mem_mc_addr;
   logic [31:0] mem_mc_wdata;
   logic [31:0] mc_mem_data;
   logic        mc_mem_ack;

   modport master (
      output if_mc_req, if_mc_addr,
      output mem_mc_req, mem_mc_we, mem_mc_addr, mem_mc_wdata,
      input  mc_if_data, mc_if_ack, mc_if_stall,
      input  mc_mem_data, mc_mem_ack
   );

   modport slave (
      input  if_mc_req, if_mc_addr,
      input  mem_mc_req, mem_mc_we, mem_mc_addr, mem_mc_wdata,
      output mc_if_data, mc_if_ack, mc_if_stall,
      output mc_mem_data, mc_mem_ack
   );

endinterface

// File: rtl/memory_controller.sv
// Arbitrates fetch reads and data loads/stores onto one fixed-latency synchronous RAM.
// Data stage has priority; each access is IDLE -> BUSY (LATENCY cycles) -> RESP (ack).
module memory_controller
   import memory_controller_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   memory_controller_if.slave bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   localparam logic [MC_CNT_W-1:0] CNT_LAST = MC_CNT_W'(LATENCY - 1);

   mc_state_e           state;
   mc_src_e             src;
   logic [MC_CNT_W-1:0] cnt;
   logic [31:0]         if_data;
   logic [31:0]         mem_data;
   logic                if_ack;
   logic                mem_ack;

   // Byte-lane bits and address bits beyond the RAM depth are dropped on purpose.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_mc_addr[31:ADDR_W+2], bus.if_mc_addr[1:0],
                               bus.mem_mc_addr[31:ADDR_W+2], bus.mem_mc_addr[1:0]};

   // NOTE: every register here, outputs included, uses non-blocking assignment so all
   // state updates see pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= MC_IDLE;
         src       <= MC_SRC_IF;
         cnt       <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         if_data   <= '0;
         mem_data  <= '0;
         if_ack    <= 1'b0;
         mem_ack   <= 1'b0;
      end else begin
         if_ack  <= 1'b0;
         mem_ack <= 1'b0;
         unique case (state)
            MC_IDLE: begin
               if (bus.mem_mc_req) begin
                  src       <= MC_SRC_MEM;
                  ram_en    <= 1'b1;
                  ram_we    <= bus.mem_mc_we;
                  ram_addr  <= bus.mem_mc_addr[ADDR_W+1:2];
                  ram_wdata <= bus.mem_mc_wdata;
                  state     <= MC_BUSY_MEM;
               end else if (bus.if_mc_req) begin
                  src      <= MC_SRC_IF;
                  ram_en   <= 1'b1;
                  ram_we   <= 1'b0;
                  ram_addr <= bus.if_mc_addr[ADDR_W+1:2];
                  state    <= MC_BUSY_IF;
               end
            end
            MC_BUSY_IF, MC_BUSY_MEM: begin
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  ram_en <= 1'b0;
                  ram_we <= 1'b0;
                  state  <= MC_RESP;
                  if (src == MC_SRC_IF) begin
                     if_data <= ram_rdata;
                     if_ack  <= 1'b1;
                  end else begin
                     // Stores complete with an ack but leave the load-data register untouched.
                     if (!ram_we) mem_data <= ram_rdata;
                     mem_ack <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            MC_RESP: state <= MC_IDLE;
            default: state <= MC_IDLE;
         endcase
      end
   end

   assign bus.mc_if_data  = if_data;
   assign bus.mc_if_ack   = if_ack;
   assign bus.mc_if_stall = bus.if_mc_req & ~if_ack;
   assign bus.mc_mem_data = mem_data;
   assign bus.mc_mem_ack  = mem_ack;

endmodule

// File: tb/tb_memory_controller.sv
// Directed plus randomized checks of memory_controller against a word-array reference model.
// Two instances: LATENCY=2 (main) and LATENCY=1 (back-to-back fetch stream).
module tb_memory_controller;

   localparam int ADDR_W = 10;
   localparam int WORDS  = 1 << ADDR_W;
   localparam int LAT_A  = 2;
   localparam int LAT_B  = 1;
   localparam logic [31:0] POISON = 32'hBAD0_BAD0;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   memory_controller_if bus_a ();
   memory_controller_if bus_b ();

   logic              ram_en_a, ram_we_a, ram_en_b, ram_we_b;
   logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
   logic [31:0]       ram_wdata_a, ram_rdata_a, ram_wdata_b, ram_rdata_b;

   memory_controller #(.ADDR_W(ADDR_W), .LATENCY(LAT_A)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a.slave),
      .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
      .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a)
   );

   memory_controller #(.ADDR_W(ADDR_W), .LATENCY(LAT_B)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b.slave),
      .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
      .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b)
   );

   function automatic logic [31:0] init_word(int w);
      if (w == 2) return 32'hDEAD_BEEF;
      return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   // Behavioural RAMs: read data is valid only from the LATENCY-th consecutive enabled cycle.
   logic [31:0] mem_a [WORDS];
   logic [31:0] mem_b [WORDS];
   int run_a = 0;
   int run_b = 0;

   initial begin
      for (int w = 0; w < WORDS; w++) begin
         mem_a[w] = init_word(w);
         mem_b[w] = init_word(w);
      end
   end

   always @(posedge clock) begin
      if (ram_en_a) begin
         if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
         run_a <= run_a + 1;
      end else run_a <= 0;
      if (ram_en_b) begin
         if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
         run_b <= run_b + 1;
      end else run_b <= 0;
   end

   assign ram_rdata_a = (ram_en_a && run_a >= LAT_A - 1) ? mem_a[ram_addr_a] : POISON;
   assign ram_rdata_b = (ram_en_b && run_b >= LAT_B - 1) ? mem_b[ram_addr_b] : POISON;

   // Reference model: initial image plus a log of stores, indexed by wrapped word address.
   logic [31:0] wr_log [int];
   logic [31:0] exp_if_a = '0, exp_mem_a = '0, exp_if_b = '0;

   function automatic int word_of(logic [31:0] byte_addr);
      return int'((byte_addr / 4) % WORDS);
   endfunction

   function automatic logic [31:0] ref_read(logic [31:0] byte_addr);
      int w;
      w = word_of(byte_addr);
      if (wr_log.exists(w)) return wr_log[w];
      return init_word(w);
   endfunction

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full access on the LATENCY=2 instance, starting and ending at a falling edge in IDLE.
   task automatic run_access(input string tag, input bit is_mem, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] exp_word;
      exp_word = 32'(word_of(addr));
      if (is_mem) begin
         bus_a.mem_mc_req   = 1'b1;
         bus_a.mem_mc_we    = we;
         bus_a.mem_mc_addr  = addr;
         bus_a.mem_mc_wdata = wdata;
      end else begin
         bus_a.if_mc_req  = 1'b1;
         bus_a.if_mc_addr = addr;
         #1 check({tag, ".stall_pre"}, bus_a.mc_if_stall, 1);
      end
      @(posedge clock);
      for (int c = 1; c <= LAT_A; c++) begin
         @(negedge clock);
         if (c == 1) begin
            // Inputs wander after acceptance; the controller must use the latched copy.
            bus_a.mem_mc_we    = ~we;
            bus_a.mem_mc_addr  = ~addr;
            bus_a.mem_mc_wdata = $urandom;
            bus_a.if_mc_addr   = ~addr;
         end
         check({tag, ".busy_en"}, ram_en_a, 1);
         check({tag, ".busy_addr"}, ram_addr_a, exp_word);
         check({tag, ".busy_we"}, ram_we_a, is_mem && we);
         if (is_mem && we) check({tag, ".busy_wdata"}, ram_wdata_a, wdata);
         check({tag, ".busy_acks"}, {bus_a.mc_if_ack, bus_a.mc_mem_ack}, 0);
         if (!is_mem) check({tag, ".busy_stall"}, bus_a.mc_if_stall, 1);
      end
      @(negedge clock);
      if (is_mem) begin
         check({tag, ".mem_ack"}, bus_a.mc_mem_ack, 1);
         check({tag, ".if_ack_quiet"}, bus_a.mc_if_ack, 0);
         if (!we) exp_mem_a = ref_read(addr);
         check({tag, ".mem_data"}, bus_a.mc_mem_data, exp_mem_a);
         bus_a.mem_mc_req = 1'b0;
      end else begin
         check({tag, ".if_ack"}, bus_a.mc_if_ack, 1);
         check({tag, ".mem_ack_quiet"}, bus_a.mc_mem_ack, 0);
         exp_if_a = ref_read(addr);
         check({tag, ".if_data"}, bus_a.mc_if_data, exp_if_a);
         check({tag, ".resp_stall"}, bus_a.mc_if_stall, 0);
         bus_a.if_mc_req = 1'b0;
      end
      check({tag, ".resp_en"}, ram_en_a, 0);
      if (is_mem && we) wr_log[word_of(addr)] = wdata;
      @(negedge clock);
      check({tag, ".idle_acks"}, {bus_a.mc_if_ack, bus_a.mc_mem_ack}, 0);
      check({tag, ".idle_en"}, ram_en_a, 0);
   endtask

   initial begin
      logic [31:0] seq [6];
      bus_a.if_mc_req = 0; bus_a.if_mc_addr = 0; bus_a.mem_mc_req = 0;
      bus_a.mem_mc_we = 0; bus_a.mem_mc_addr = 0; bus_a.mem_mc_wdata = 0;
      bus_b.if_mc_req = 0; bus_b.if_mc_addr = 0; bus_b.mem_mc_req = 0;
      bus_b.mem_mc_we = 0; bus_b.mem_mc_addr = 0; bus_b.mem_mc_wdata = 0;

      // Reset state
      #1 reset = 1'b0;
      #1;
      check("rst.en", ram_en_a, 0);
      check("rst.we", ram_we_a, 0);
      check("rst.acks", {bus_a.mc_if_ack, bus_a.mc_mem_ack}, 0);
      check("rst.data", bus_a.mc_if_data | bus_a.mc_mem_data, 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Fetch of preloaded word 2
      run_access("fetch8", 0, 0, 32'h0000_0008, 0);

      // Store then load at the same address
      run_access("store40", 1, 1, 32'h0000_0040, 32'h1234_5678);
      run_access("load40", 1, 0, 32'h0000_0040, 0);

      // Simultaneous fetch and load: load wins, fetch follows
      bus_a.if_mc_req = 1; bus_a.if_mc_addr = 32'h0;
      bus_a.mem_mc_req = 1; bus_a.mem_mc_we = 0; bus_a.mem_mc_addr = 32'h4;
      @(posedge clock);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clock);
         check("both.ack_exclusive", bus_a.mc_if_ack & bus_a.mc_mem_ack, 0);
         if (c <= 2 || c == 5 || c == 6) begin
            check("both.en", ram_en_a, 1);
            check("both.addr", ram_addr_a, (c <= 2) ? 1 : 0);
         end else if (c == 3) begin
            check("both.mem_ack", bus_a.mc_mem_ack, 1);
            exp_mem_a = ref_read(32'h4);
            check("both.mem_data", bus_a.mc_mem_data, exp_mem_a);
            check("both.stall_pending", bus_a.mc_if_stall, 1);
            bus_a.mem_mc_req = 0;
         end else if (c == 4) begin
            check("both.idle_acks", {bus_a.mc_if_ack, bus_a.mc_mem_ack}, 0);
            check("both.idle_en", ram_en_a, 0);
         end else begin
            check("both.if_ack", bus_a.mc_if_ack, 1);
            exp_if_a = ref_read(32'h0);
            check("both.if_data", bus_a.mc_if_data, exp_if_a);
            bus_a.if_mc_req = 0;
         end
      end
      @(negedge clock);

      // Misaligned and wrapped addresses both map to word 2
      run_access("misalign", 0, 0, 32'h0000_000B, 0);
      run_access("wrap", 1, 0, 32'h0000_1008, 0);

      // LATENCY=1 instance: fetch request held high, address changed after each ack
      seq[0] = 32'h0000_0010; seq[1] = 32'h0000_0014; seq[2] = 32'h0000_0FFC;
      for (int k = 3; k < 6; k++) seq[k] = $urandom;
      bus_b.if_mc_req = 1; bus_b.if_mc_addr = seq[0];
      @(posedge clock);
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         check("lat1.busy_en", ram_en_b, 1);
         check("lat1.busy_addr", ram_addr_b, 32'(word_of(seq[k])));
         check("lat1.busy_ack", bus_b.mc_if_ack, 0);
         @(negedge clock);
         check("lat1.ack", bus_b.mc_if_ack, 1);
         exp_if_b = init_word(word_of(seq[k]));
         check("lat1.data", bus_b.mc_if_data, exp_if_b);
         if (k < 5) bus_b.if_mc_addr = seq[k + 1];
         else bus_b.if_mc_req = 0;
         @(negedge clock);
         check("lat1.idle_ack", bus_b.mc_if_ack, 0);
         check("lat1.idle_en", ram_en_b, 0);
         if (k < 5) check("lat1.idle_stall", bus_b.mc_if_stall, 1);
      end

      // Randomized traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         bit          m;
         bit          w;
         logic [31:0] a;
         m = 1'($urandom_range(0, 1));
         w = m ? 1'($urandom_range(0, 1)) : 1'b0;
         a = $urandom & 32'hFFFF_F03F;
         run_access(m ? (w ? "rnd_st" : "rnd_ld") : "rnd_if", m, w, a, $urandom);
      end

      // Asynchronous reset in the second busy cycle of a load
      bus_a.mem_mc_req = 1; bus_a.mem_mc_we = 0; bus_a.mem_mc_addr = 32'h0000_0100;
      @(posedge clock);
      @(negedge clock);
      @(negedge clock);
      check("rstmid.en_before", ram_en_a, 1);
      #2 reset = 1'b0;
      #1;
      check("rstmid.en", ram_en_a, 0);
      check("rstmid.we", ram_we_a, 0);
      check("rstmid.acks", {bus_a.mc_if_ack, bus_a.mc_mem_ack}, 0);
      exp_if_a = '0; exp_mem_a = '0; exp_if_b = '0;
      check("rstmid.data_a", {bus_a.mc_if_data, bus_a.mc_mem_data}, 0);
      check("rstmid.data_b", bus_b.mc_if_data, exp_if_b);
      bus_a.mem_mc_req = 0;
      @(negedge clock);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clock);
         check("rstmid.no_ack", {bus_a.mc_if_ack, bus_a.mc_mem_ack}, 0);
         check("rstmid.idle_en", ram_en_a, 0);
      end
      run_access("post_rst", 1, 0, 32'h0000_0040, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
